// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write scheduler slice.
package fb_pkg;
  localparam int COORD_W   = 10;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the scan at rr_ptr; pointer
// advances past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter  int NUM_ENG = 4,
  localparam int IDX_W   = $clog2(NUM_ENG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_ENG-1:0] req,
  input  logic               en,
  output logic [NUM_ENG-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  localparam int unsigned N = NUM_ENG;

  logic [IDX_W-1:0] rr_ptr;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((32'(rr_ptr) + k) % N);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: HPS > round-robin engines, plus a
// full-frame clear sequencer. Optional counters under FB_WR_STATS_EN.
module fb_write_scheduler
  import fb_pkg::*;
#(
  parameter int NUM_ENG = 4,
  parameter int WIDTH   = 8,
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_ENG-1:0]         eng_valid,
  output logic [NUM_ENG-1:0]         eng_ready,
  input  logic [COORD_W*NUM_ENG-1:0] eng_x,
  input  logic [COORD_W*NUM_ENG-1:0] eng_y,
  input  logic [WIDTH*NUM_ENG-1:0]   eng_rgb,
  input  logic                       hps_valid,
  output logic                       hps_ready,
  input  logic [COORD_W-1:0]         hps_x,
  input  logic [COORD_W-1:0]         hps_y,
  input  logic [WIDTH-1:0]           hps_rgb,
  input  logic                       clear_start,
  input  logic [WIDTH-1:0]           clear_rgb,
  output logic                       clear_busy,
  output logic                       clear_done,
`ifdef FB_WR_STATS_EN
  output logic [15:0]                drop_cnt,
  output logic [31:0]                wr_cnt,
`endif
  output logic                       fb_write,
  output logic [COORD_W-1:0]         fb_x,
  output logic [COORD_W-1:0]         fb_y,
  output logic [WIDTH-1:0]           fb_wrgb
);
  localparam int IDX_W = $clog2(NUM_ENG);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  state_t             state;
  logic [COORD_W-1:0] cx, cy;
  logic [WIDTH-1:0]   crgb;

  logic               arb_open;
  logic [IDX_W-1:0]   gidx;
  logic               xfer;
  logic               in_range;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [WIDTH-1:0]   sel_rgb;

  // A clear_start in ARB closes the port for that cycle so it cannot race a grant.
  assign arb_open  = (state == ARB) && !clear_start;
  assign hps_ready = arb_open && hps_valid;

  rr_arbiter #(.NUM_ENG(NUM_ENG)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (eng_valid),
    .en       (arb_open && !hps_valid),
    .grant    (eng_ready),
    .grant_idx(gidx)
  );

  always_comb begin
    sel_x   = hps_x;
    sel_y   = hps_y;
    sel_rgb = hps_rgb;
    if (!hps_ready) begin
      sel_x   = eng_x[gidx*COORD_W +: COORD_W];
      sel_y   = eng_y[gidx*COORD_W +: COORD_W];
      sel_rgb = eng_rgb[gidx*WIDTH +: WIDTH];
    end
  end

  assign xfer     = hps_ready || (|eng_ready);
  assign in_range = (sel_x <= X_MAX) && (sel_y <= Y_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      cx         <= '0;
      cy         <= '0;
      crgb       <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      fb_write   <= 1'b0;
      fb_x       <= '0;
      fb_y       <= '0;
      fb_wrgb    <= '0;
    end else begin
      fb_write   <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ARB: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            crgb       <= clear_rgb;
            cx         <= '0;
            cy         <= '0;
          end else if (xfer && in_range) begin
            fb_write <= 1'b1;
            fb_x     <= sel_x;
            fb_y     <= sel_y;
            fb_wrgb  <= sel_rgb;
          end
        end
        CLEAR: begin
          fb_write <= 1'b1;
          fb_x     <= cx;
          fb_y     <= cy;
          fb_wrgb  <= crgb;
          if (cx == X_MAX) begin
            cx <= '0;
            if (cy == Y_MAX) begin
              state      <= ARB;
              clear_busy <= 1'b0;
              clear_done <= 1'b1;
            end else begin
              cy <= cy + 1'b1;
            end
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

`ifdef FB_WR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      wr_cnt   <= '0;
    end else begin
      if (xfer && !in_range && (drop_cnt != '1))
        drop_cnt <= drop_cnt + 1'b1;
      if ((state == CLEAR) || (xfer && in_range))
        wr_cnt <= wr_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Randomized bench for fb_write_scheduler against a queue-based model of
// the arbitration and clear rules. Stats checks follow FB_WR_STATS_EN.
module tb_fb_write_scheduler;
  localparam int NE = 4;
  localparam int W  = 8;
  localparam int HR = 8;
  localparam int VR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NE-1:0]   eng_valid, eng_ready;
  logic [10*NE-1:0] eng_x, eng_y;
  logic [W*NE-1:0] eng_rgb;
  logic            hps_valid, hps_ready;
  logic [9:0]      hps_x, hps_y;
  logic [W-1:0]    hps_rgb;
  logic            clear_start;
  logic [W-1:0]    clear_rgb;
  logic            clear_busy, clear_done;
  logic            fb_write;
  logic [9:0]      fb_x, fb_y;
  logic [W-1:0]    fb_wrgb;
`ifdef FB_WR_STATS_EN
  logic [15:0]     drop_cnt;
  logic [31:0]     wr_cnt;
`endif

  always #5 clk = ~clk;

  fb_write_scheduler #(.NUM_ENG(NE), .WIDTH(W), .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .rst(rst),
    .eng_valid(eng_valid), .eng_ready(eng_ready),
    .eng_x(eng_x), .eng_y(eng_y), .eng_rgb(eng_rgb),
    .hps_valid(hps_valid), .hps_ready(hps_ready),
    .hps_x(hps_x), .hps_y(hps_y), .hps_rgb(hps_rgb),
    .clear_start(clear_start), .clear_rgb(clear_rgb),
    .clear_busy(clear_busy), .clear_done(clear_done),
`ifdef FB_WR_STATS_EN
    .drop_cnt(drop_cnt), .wr_cnt(wr_cnt),
`endif
    .fb_write(fb_write), .fb_x(fb_x), .fb_y(fb_y), .fb_wrgb(fb_wrgb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester state (held until accepted)
  bit e_v[NE];
  int e_x[NE], e_y[NE], e_c[NE];
  bit h_v;
  int h_x, h_y, h_c;
  bit cstart;
  int crgb_in;

  // Reference model
  typedef struct { int x; int y; int c; } wr_t;
  wr_t cq[$];
  int  m_ptr, m_fx, m_fy, m_fc, m_drop, m_wr, last_grant;
  bit  m_busy, m_fw, m_done;

  task automatic apply_inputs();
    for (int i = 0; i < NE; i++) begin
      eng_valid[i]         = e_v[i];
      eng_x[i*10 +: 10]    = 10'(e_x[i]);
      eng_y[i*10 +: 10]    = 10'(e_y[i]);
      eng_rgb[i*W +: W]    = W'(e_c[i]);
    end
    hps_valid   = h_v;
    hps_x       = 10'(h_x);
    hps_y       = 10'(h_y);
    hps_rgb     = W'(h_c);
    clear_start = cstart;
    clear_rgb   = W'(crgb_in);
  endtask

  function automatic void accept(input int x, input int y, input int c);
    if (x < HR && y < VR) begin
      m_fw = 1; m_fx = x; m_fy = y; m_fc = c;
    end else if (m_drop < 65535) begin
      m_drop++;
    end
  endfunction

  function automatic int rnd_coord(input int lim);
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(lim, 1023));
    return int'($urandom_range(0, lim - 1));
  endfunction

  task automatic cycle();
    int g;
    bit hg;
    logic [NE-1:0] er;
    wr_t w;
    apply_inputs();
    #1;
    g = -1; hg = 0; er = '0;
    if (!m_busy && !cstart) begin
      if (h_v) hg = 1;
      else
        for (int k = 0; k < NE; k++)
          if (g < 0 && e_v[(m_ptr + k) % NE]) g = (m_ptr + k) % NE;
    end
    if (g >= 0) er[g] = 1'b1;
    check("eng_ready", 32'(eng_ready), 32'(er));
    check("hps_ready", 32'(hps_ready), 32'(hg));
    last_grant = g;
    m_fw = 0; m_done = 0;
    if (m_busy) begin
      w = cq.pop_front();
      m_fw = 1; m_fx = w.x; m_fy = w.y; m_fc = w.c;
      if (cq.size() == 0) begin m_busy = 0; m_done = 1; end
    end else if (cstart) begin
      for (int y = 0; y < VR; y++)
        for (int x = 0; x < HR; x++) cq.push_back('{x, y, crgb_in & 8'hFF});
      m_busy = 1;
    end else if (hg) begin
      accept(h_x, h_y, h_c); h_v = 0;
    end else if (g >= 0) begin
      accept(e_x[g], e_y[g], e_c[g]); e_v[g] = 0; m_ptr = (g + 1) % NE;
    end
    if (m_fw) m_wr++;
    @(posedge clk); #1;
    check("fb_write", 32'(fb_write), 32'(m_fw));
    check("fb_x", 32'(fb_x), 32'(m_fx));
    check("fb_y", 32'(fb_y), 32'(m_fy));
    check("fb_wrgb", 32'(fb_wrgb), 32'(m_fc));
    check("clear_busy", 32'(clear_busy), 32'(m_busy));
    check("clear_done", 32'(clear_done), 32'(m_done));
`ifdef FB_WR_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("wr_cnt", wr_cnt, 32'(m_wr));
`endif
    cstart = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NE; i++) e_v[i] = 0;
    h_v = 0; cstart = 0;
    apply_inputs();
    @(posedge clk); #1;
    m_ptr = 0; m_busy = 0; cq.delete();
    m_fw = 0; m_done = 0; m_fx = 0; m_fy = 0; m_fc = 0; m_drop = 0; m_wr = 0;
    check("rst_fb_write", 32'(fb_write), 0);
    check("rst_fb_x", 32'(fb_x), 0);
    check("rst_fb_y", 32'(fb_y), 0);
    check("rst_fb_wrgb", 32'(fb_wrgb), 0);
    check("rst_clear_busy", 32'(clear_busy), 0);
    check("rst_clear_done", 32'(clear_done), 0);
    check("rst_eng_ready", 32'(eng_ready), 0);
    check("rst_hps_ready", 32'(hps_ready), 0);
`ifdef FB_WR_STATS_EN
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_wr_cnt", wr_cnt, 0);
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic arm_eng(input int i);
    e_v[i] = 1;
    e_x[i] = int'($urandom_range(0, HR - 1));
    e_y[i] = int'($urandom_range(0, VR - 1));
    e_c[i] = int'($urandom_range(0, 255));
  endtask

  int wcount, dcount;

  initial begin
    for (int i = 0; i < NE; i++) begin e_x[i] = 0; e_y[i] = 0; e_c[i] = 0; end
    h_x = 0; h_y = 0; h_c = 0; crgb_in = 0;
    do_reset();

    // Idle after reset
    for (int n = 0; n < 20; n++) cycle();

    // All engines valid: strict rotation from engine 0
    for (int i = 0; i < NE; i++) arm_eng(i);
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("rr_order", 32'(last_grant), 32'(k % NE));
      if (last_grant >= 0) arm_eng(last_grant);
    end
    for (int i = 0; i < NE; i++) e_v[i] = 0;

    // HPS priority over engines 1 and 2, then engines resume in order
    arm_eng(1); arm_eng(2);
    for (int k = 0; k < 5; k++) begin
      h_v = 1; h_x = int'($urandom_range(0, HR - 1)); h_y = int'($urandom_range(0, VR - 1));
      h_c = int'($urandom_range(0, 255));
      cycle();
      check("hps_prio", 32'(last_grant), 32'(-1));
    end
    cycle();
    check("after_hps_first", 32'(last_grant), 1);
    cycle();
    check("after_hps_second", 32'(last_grant), 2);

    // Out-of-range request is accepted but dropped
    e_v[0] = 1; e_x[0] = 640; e_y[0] = 5; e_c[0] = 8'h55;
    cycle();
    check("drop_grant", 32'(last_grant), 0);
    check("drop_no_write", 32'(fb_write), 0);

    // Full clear with engines pestering throughout
    for (int i = 0; i < NE; i++) arm_eng(i);
    crgb_in = 8'h1F; cstart = 1;
    cycle();
    wcount = 0; dcount = 0;
    for (int k = 0; k < HR * VR; k++) begin
      if (k == 5) cstart = 1;
      cycle();
      wcount += int'(fb_write);
      if (clear_done) begin
        dcount++;
        check("done_at_last", {fb_x, fb_y}, {10'd7, 10'd3} );
      end
    end
    check("clear_writes", 32'(wcount), 32'(HR * VR));
    check("clear_done_count", 32'(dcount), 1);
    for (int n = 0; n < 4; n++) cycle();

    // Reset ten cycles into a clear
    crgb_in = 8'hA5; cstart = 1;
    cycle();
    for (int n = 0; n < 10; n++) cycle();
    do_reset();
    for (int n = 0; n < 3; n++) cycle();
    arm_eng(2);
    cycle();
    check("post_reset_grant", 32'(last_grant), 2);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NE; i++)
        if (!e_v[i] && $urandom_range(0, 1) == 1) begin
          e_v[i] = 1; e_x[i] = rnd_coord(HR); e_y[i] = rnd_coord(VR);
          e_c[i] = int'($urandom_range(0, 255));
        end
      if (!h_v && $urandom_range(0, 7) == 0) begin
        h_v = 1; h_x = rnd_coord(HR); h_y = rnd_coord(VR); h_c = int'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 149) == 0) begin
        cstart = 1; crgb_in = int'($urandom_range(0, 255));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
